alu_seq_acc: RTL and testbench
==============================

# alu_seq_acc

Parametrised sequential ALU with an accumulator, status flags and a valid/ready input handshake. It extends the 2-bit combinational ALU instruction set to WIDTH-bit operands and registers every result. It adds an iterative unsigned multiply and accumulator chaining. It sits between the pin-mapping top level and the operand/op decode logic, and its result and flags drive the output pins.

## Interface
- WIDTH, 4, operand and accumulator width in bits (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  op/operands present
- in_ready  output  1  block can accept; combinational, equals (state == IDLE)
- op  input  4  operation code, see Operation
- a  input  WIDTH  operand A (ignored when use_acc=1)
- b  input  WIDTH  operand B
- use_acc  input  1  take operand A from accumulator
- out_valid  output  1  one-cycle pulse: result/flags updated
- result  output  2*WIDTH  registered result; upper WIDTH bits nonzero only for MUL
- acc  output  WIDTH  accumulator register
- flag_c  output  1  carry / borrow / shifted-out bit
- flag_v  output  1  signed overflow (ADD/SUB only, else 0)
- flag_z  output  1  result zero
- flag_n  output  1  result sign bit
- flag_err  output  1  illegal op code

## Operation
- Accept: in_valid & in_ready at a rising edge. Operand A = use_acc ? acc : a, sampled at accept.
- Op codes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 NOT A (B ignored), 0110 SHL A by 1, 0111 SHR A by 1 logical, 1000 MUL unsigned, 1001 CLR, 1010–1111 illegal.
- Single-cycle ops (0000–0111, 1001): result[WIDTH-1:0] = op result, result[2W-1:W] = 0.
- ADD: flag_c = carry out of bit WIDTH-1; flag_v = (A,B same sign) & (sum sign differs).
- SUB: A − B mod 2^WIDTH; flag_c = borrow (1 iff A < B unsigned); flag_v = (A,B signs differ) & (diff sign ≠ A sign).
- SHL: flag_c = A[WIDTH-1]. SHR: flag_c = A[0]. Logic ops, NOT, CLR, MUL: flag_c = 0.
- CLR: result = 0, acc = 0.
- MUL: full 2*WIDTH product, shift-add, one partial-product step per cycle.
- flag_z: low WIDTH bits zero (MUL: all 2*WIDTH bits zero). flag_n: result[WIDTH-1] (MUL: result[2W-1]).
- acc <= result[WIDTH-1:0] on every completed legal op.
- Illegal op: result = 0, flag_err = 1, other flags 0, acc unchanged, out_valid still pulses. flag_err clears on next legal completion.
- FSM: IDLE –accept MUL→ MUL; MUL –iteration counter reaches WIDTH→ IDLE. All other accepted ops complete in IDLE.
- Counter width ceil(log2(WIDTH+1)). Multiplicand, multiplier and partial-sum working registers are separate from result.

## Timing
- Reset (async assert, released synchronously by the clock domain): state IDLE, result 0, acc 0, all flags 0, out_valid 0, counter 0. in_ready reads 1 during and after reset.
- Single-cycle op accepted at edge k: result, flags and acc valid after edge k; out_valid high for cycle k→k+1 only.
- Back-to-back single-cycle ops accepted on consecutive edges, one result per cycle. use_acc on the op after a completion sees the just-written acc.
- MUL accepted at edge k: in_ready = 0 for WIDTH cycles. Iterations occur on edges k+1..k+WIDTH. Result, flags and acc update and out_valid pulses after edge k+WIDTH. in_ready returns to 1 in the same cycle. Next accept is possible at edge k+WIDTH+1.
- in_valid while in_ready = 0 is ignored and not queued. Inputs need not be held during MUL.
- No output backpressure; result/flags hold until the next completion.
- Reset mid-MUL aborts: no out_valid, acc = 0.

## Test plan
- WIDTH=4, ADD a=7 b=9 → result 0x00, c=1, z=1, v=0, n=0; ADD a=7 b=1 → 0x08, v=1, n=1, c=0.
- SUB a=3 b=5 → result 0x0E, c=1, n=1, v=0; SUB a=8 b=1 → 0x07, v=1, c=0.
- MUL a=15 b=15 → in_ready low 4 cycles, out_valid after 4th edge, result 0xE1, acc 0x1, n=1, z=0.
- Chaining: ADD a=2 b=3 (acc=5), then ADD use_acc=1 b=4 next cycle → result 0x09; then CLR → acc 0, z=1; SHL a=0x9 → 0x02, c=1.
- Illegal op 1111 with acc=5 → out_valid pulse, flag_err=1, result 0, acc stays 5; next AND a=0xF b=0x3 → 0x03, flag_err=0.
- Assert rst_n low 2 cycles into MUL a=3 b=3 → no out_valid, all outputs 0, in_ready 1. Then MUL 3×3 after release → 0x09.

Source files
------------

// File: rtl/alu_seq_acc_if.sv
// Operand/op handshake and result/flag bus for alu_seq_acc.
// The slave modport is the ALU side; the master modport is the requester.
interface alu_seq_acc_if #(
  parameter int WIDTH = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [3:0]         op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               use_acc;
  logic               out_valid;
  logic [2*WIDTH-1:0] result;
  logic [WIDTH-1:0]   acc;
  logic               flag_c;
  logic               flag_v;
  logic               flag_z;
  logic               flag_n;
  logic               flag_err;

  modport master (
    output in_valid, op, a, b, use_acc,
    input  in_ready, out_valid, result, acc,
    input  flag_c, flag_v, flag_z, flag_n, flag_err
  );

  modport slave (
    input  in_valid, op, a, b, use_acc,
    output in_ready, out_valid, result, acc,
    output flag_c, flag_v, flag_z, flag_n, flag_err
  );
endinterface

// File: rtl/alu_seq_acc.sv
// Sequential WIDTH-bit ALU with accumulator, status flags and an iterative
// shift-add unsigned multiplier; every result is registered.
module alu_seq_acc #(
  parameter int WIDTH = 4
) (
  input logic         clk,
  input logic         rst_n,
  alu_seq_acc_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {S_IDLE, S_MUL} state_e;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3,
    OP_XOR = 4'h4, OP_NOT = 4'h5, OP_SHL = 4'h6, OP_SHR = 4'h7,
    OP_MUL = 4'h8, OP_CLR = 4'h9
  } op_e;

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               c_q, c_d, v_q, v_d, z_q, z_d, n_q, n_d, err_q, err_d;
  logic               out_valid_q, out_valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] psum_q, psum_d;

  logic               in_ready;
  logic               accept;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH:0]     sum_w;
  logic [WIDTH:0]     dif_w;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;
  logic               alu_legal;
  logic [2*WIDTH-1:0] psum_nxt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               mul_last;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && bus.op == OP_MUL) state_d = S_MUL;
      S_MUL:   if (mul_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready     = (state_q == S_IDLE);
    bus.in_ready = in_ready;
    bus.out_valid = out_valid_q;
    bus.result   = result_q;
    bus.acc      = acc_q;
    bus.flag_c   = c_q;
    bus.flag_v   = v_q;
    bus.flag_z   = z_q;
    bus.flag_n   = n_q;
    bus.flag_err = err_q;
  end

  assign accept = bus.in_valid & in_ready;

  // Single-cycle operation unit
  always_comb begin
    op_a      = bus.use_acc ? acc_q : bus.a;
    sum_w     = {1'b0, op_a} + {1'b0, bus.b};
    dif_w     = {1'b0, op_a} - {1'b0, bus.b};
    alu_res   = '0;
    alu_c     = 1'b0;
    alu_v     = 1'b0;
    alu_legal = 1'b1;
    case (bus.op)
      OP_ADD: begin
        alu_res = sum_w[WIDTH-1:0];
        alu_c   = sum_w[WIDTH];
        alu_v   = (op_a[WIDTH-1] == bus.b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = dif_w[WIDTH-1:0];
        alu_c   = dif_w[WIDTH];
        alu_v   = (op_a[WIDTH-1] != bus.b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_AND: alu_res = op_a & bus.b;
      OP_OR:  alu_res = op_a | bus.b;
      OP_XOR: alu_res = op_a ^ bus.b;
      OP_NOT: alu_res = ~op_a;
      OP_SHL: begin
        alu_res = {op_a[WIDTH-2:0], 1'b0};
        alu_c   = op_a[WIDTH-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, op_a[WIDTH-1:1]};
        alu_c   = op_a[0];
      end
      OP_MUL: alu_res = '0;
      OP_CLR: alu_res = '0;
      default: alu_legal = 1'b0;
    endcase
  end

  // One shift-add partial product per cycle; the WIDTH-th step completes
  assign psum_nxt = psum_q + (mplier_q[0] ? mcand_q : '0);
  assign cnt_nxt  = cnt_q + CNT_W'(1);
  assign mul_last = (state_q == S_MUL) && (cnt_nxt == CNT_W'(WIDTH));

  always_comb begin
    result_d    = result_q;
    acc_d       = acc_q;
    c_d         = c_q;
    v_d         = v_q;
    z_d         = z_q;
    n_d         = n_q;
    err_d       = err_q;
    out_valid_d = 1'b0;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    psum_d      = psum_q;
    if (accept) begin
      if (bus.op == OP_MUL) begin
        mcand_d  = {{WIDTH{1'b0}}, op_a};
        mplier_d = bus.b;
        psum_d   = '0;
        cnt_d    = '0;
      end else if (alu_legal) begin
        result_d    = {{WIDTH{1'b0}}, alu_res};
        acc_d       = alu_res;
        c_d         = alu_c;
        v_d         = alu_v;
        z_d         = (alu_res == '0);
        n_d         = alu_res[WIDTH-1];
        err_d       = 1'b0;
        out_valid_d = 1'b1;
      end else begin
        result_d    = '0;
        c_d         = 1'b0;
        v_d         = 1'b0;
        z_d         = 1'b0;
        n_d         = 1'b0;
        err_d       = 1'b1;
        out_valid_d = 1'b1;
      end
    end else if (state_q == S_MUL) begin
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      psum_d   = psum_nxt;
      cnt_d    = cnt_nxt;
      if (mul_last) begin
        result_d    = psum_nxt;
        acc_d       = psum_nxt[WIDTH-1:0];
        c_d         = 1'b0;
        v_d         = 1'b0;
        z_d         = (psum_nxt == '0);
        n_d         = psum_nxt[2*WIDTH-1];
        err_d       = 1'b0;
        out_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= '0;
      acc_q       <= '0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      psum_q      <= '0;
    end else begin
      result_q    <= result_d;
      acc_q       <= acc_d;
      c_q         <= c_d;
      v_q         <= v_d;
      z_q         <= z_d;
      n_q         <= n_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      psum_q      <= psum_d;
    end
  end
endmodule

// File: tb/tb_alu_seq_acc.sv
// Scoreboard bench for alu_seq_acc: expectations are queued at accept time
// from an arithmetic reference model and popped whenever out_valid is seen.
module tb_alu_seq_acc;
  localparam int W = 4;
  localparam int M = 2 ** W;

  typedef struct packed {
    logic [2*W-1:0] result;
    logic [W-1:0]   acc;
    logic           c;
    logic           v;
    logic           z;
    logic           n;
    logic           err;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_seq_acc_if #(.WIDTH(W)) bus ();
  alu_seq_acc #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  obs_t exp_q[$];
  obs_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   acc_m  = 0;
  bit   ok;
  int   busy;

  function automatic obs_t observe();
    return {bus.result, bus.acc, bus.flag_c, bus.flag_v, bus.flag_z, bus.flag_n, bus.flag_err};
  endfunction

  function automatic obs_t mk(input int r, input int ac, input bit c, input bit v,
                              input bit z, input bit n, input bit e);
    obs_t o;
    o.result = (2*W)'(r);
    o.acc    = W'(ac);
    o.c = c; o.v = v; o.z = z; o.n = n; o.err = e;
    return o;
  endfunction

  function automatic int sgn(input int x);
    return (x >= M / 2) ? x - M : x;
  endfunction

  function automatic bit fits(input int x);
    return (x <= M / 2 - 1) && (x >= -(M / 2));
  endfunction

  // Reference behaviour in plain integer arithmetic
  function automatic obs_t model(input int op, input int A, input int B, input int acc_in);
    int r;
    bit c, v, legal;
    r = 0; c = 0; v = 0; legal = 1;
    case (op)
      0: begin r = (A + B) % M; c = (A + B) >= M; v = !fits(sgn(A) + sgn(B)); end
      1: begin r = (A - B + M) % M; c = A < B; v = !fits(sgn(A) - sgn(B)); end
      2: r = A & B;
      3: r = A | B;
      4: r = A ^ B;
      5: r = M - 1 - A;
      6: begin r = (2 * A) % M; c = A >= M / 2; end
      7: begin r = A / 2; c = (A % 2) == 1; end
      8: r = A * B;
      9: r = 0;
      default: legal = 0;
    endcase
    if (!legal) return mk(0, acc_in, 0, 0, 0, 0, 1);
    return mk(r, r % M, c, v, r == 0, (op == 8) ? (r >= M * M / 2) : (r >= M / 2), 0);
  endfunction

  task automatic chk_obs(input string name, input obs_t act, input obs_t e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: actual res=%h acc=%h c/v/z/n/err=%b%b%b%b%b, required res=%h acc=%h c/v/z/n/err=%b%b%b%b%b",
               name, act.result, act.acc, act.c, act.v, act.z, act.n, act.err,
               e.result, e.acc, e.c, e.v, e.z, e.n, e.err);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int e);
    checks++;
    if (act != e) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, e);
    end
  endtask

  // Monitor: every out_valid pulse consumes one queued expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: actual res=%h required no completion", bus.result);
      end else begin
        mon_e = exp_q.pop_front();
        chk_obs("scoreboard", observe(), mon_e);
      end
    end
  end

  task automatic send(input int op, input int a, input int b, input bit ua, output bit acc_ok);
    obs_t e;
    acc_ok = 0;
    for (int t = 0; t < 20 && !acc_ok; t++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.op       = 4'(op);
      bus.a        = W'(a);
      bus.b        = W'(b);
      bus.use_acc  = ua;
      if (bus.in_ready === 1'b1) begin
        e = model(op, ua ? acc_m : a, b, acc_m);
        acc_m = int'(e.acc);
        exp_q.push_back(e);
        @(posedge clk);
        acc_ok = 1;
      end
    end
    if (!acc_ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: actual in_ready=%b required 1 within 20 cycles", bus.in_ready);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic settle_check(input string name, input obs_t e);
    idle();
    chk_obs(name, observe(), e);
    chk_int({name, "_ov"}, int'(bus.out_valid), 1);
  endtask

  task automatic mul_check(input string name, input obs_t e);
    int cnt;
    cnt = 0;
    for (int t = 0; t < 20; t++) begin
      idle();
      if (bus.in_ready === 1'b1) break;
      cnt++;
    end
    chk_int({name, "_busy"}, cnt, W);
    chk_int({name, "_ov"}, int'(bus.out_valid), 1);
    chk_obs(name, observe(), e);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.op = '0; bus.a = '0; bus.b = '0; bus.use_acc = 1'b0;
    #1;
    chk_int("rst_ready", int'(bus.in_ready), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_obs("rst_state", observe(), mk(0, 0, 0, 0, 0, 0, 0));
    chk_int("rst_ov", int'(bus.out_valid), 0);
    chk_int("rst_ready_after", int'(bus.in_ready), 1);

    send(0, 7, 9, 0, ok);  settle_check("add_7_9", mk(8'h00, 0, 1, 0, 1, 0, 0));
    send(0, 7, 1, 0, ok);  settle_check("add_7_1", mk(8'h08, 8, 0, 1, 0, 1, 0));
    send(1, 3, 5, 0, ok);  settle_check("sub_3_5", mk(8'h0E, 14, 1, 0, 0, 1, 0));
    send(1, 8, 1, 0, ok);  settle_check("sub_8_1", mk(8'h07, 7, 0, 1, 0, 0, 0));
    send(8, 15, 15, 0, ok); mul_check("mul_15_15", mk(8'hE1, 1, 0, 0, 0, 1, 0));

    send(0, 2, 3, 0, ok);
    send(0, 0, 4, 1, ok);  settle_check("chain_acc", mk(8'h09, 9, 0, 1, 0, 1, 0));
    send(9, 5, 5, 0, ok);  settle_check("clr", mk(0, 0, 0, 0, 1, 0, 0));
    send(6, 9, 0, 0, ok);  settle_check("shl_9", mk(8'h02, 2, 1, 0, 0, 0, 0));

    send(0, 2, 3, 0, ok);  idle();
    send(15, 1, 1, 0, ok); settle_check("illegal", mk(0, 5, 0, 0, 0, 0, 1));
    send(2, 15, 3, 0, ok); settle_check("and_after_err", mk(8'h03, 3, 0, 0, 0, 0, 0));

    // Reset two cycles into a multiply: the queued completion must never appear
    send(8, 3, 3, 0, ok);
    idle();
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    acc_m = 0;
    #1;
    chk_obs("midmul_rst", observe(), mk(0, 0, 0, 0, 0, 0, 0));
    chk_int("midmul_rst_ready", int'(bus.in_ready), 1);
    @(negedge clk);
    chk_int("midmul_rst_ov", int'(bus.out_valid), 0);
    rst_n = 1'b1;
    send(8, 3, 3, 0, ok);  mul_check("mul_3_3", mk(8'h09, 9, 0, 0, 0, 0, 0));

    for (int i = 0; i < 250; i++) begin
      int op;
      op = ($urandom_range(0, 4) == 0) ? 8 : int'($urandom_range(0, 15));
      send(op, int'($urandom_range(0, M - 1)), int'($urandom_range(0, M - 1)),
           bit'($urandom_range(0, 1)), ok);
      if ($urandom_range(0, 3) == 0) idle();
    end
    repeat (W + 3) idle();
    chk_int("drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
